// File: rtl/usb_fs_tx_serializer.sv
// Full-speed USB line transmitter: SYNC, NRZI, bit stuffing, LSB-first bytes, then EOP.
// Define USB_TX_CRC16_EN to append a CRC16 after the data bytes when tx_crc16_i is set at start.
module usb_fs_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       tx_crc16_i,
  output logic       dp_tx_o,
  output logic       dn_tx_o,
  output logic       tx_oe_o,
  output logic       tx_busy_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SLOT_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    CRC_LO  = 3'd3,
    CRC_HI  = 3'd4,
    EOP_SE0 = 3'd5,
    EOP_J   = 3'd6
  } state_t;

  state_t         state;
  state_t         nstate;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [2:0]     nidx;
  logic [7:0]     shreg;
  logic [7:0]     load_byte;
  logic [2:0]     ones;
  logic           line;
  logic           nl;
  logic           send;
  logic           sbit;
  logic           load;
  logic           eop_cnt;
  logic           rdy_next;
  logic           slot_end;

`ifdef USB_TX_CRC16_EN
  logic [15:0]    crc;
  logic           crc_en;

  // Reflected CRC16 (poly 0xA001), one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) begin
        r = (r >> 1) ^ 16'hA001;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction
`else
  logic unused_crc_sel;
  assign unused_crc_sel = tx_crc16_i;
`endif

  assign slot_end = (cnt == SLOT_LAST);

  // Decide what the next bit slot carries: stuff bit, next bit, next byte or end of payload.
  always_comb begin
    nstate    = state;
    send      = 1'b0;
    sbit      = 1'b0;
    nidx      = bit_idx;
    load      = 1'b0;
    load_byte = shreg;
    case (state)
      SYNC, DATA, CRC_LO, CRC_HI: begin
        if (ones == 3'd6) begin
          send = 1'b1;
          sbit = 1'b0;
        end else if (bit_idx != 3'd7) begin
          send = 1'b1;
          nidx = bit_idx + 3'd1;
          sbit = shreg[nidx];
        end else if (((state == SYNC) || (state == DATA)) && tx_ready_o) begin
          nstate    = DATA;
          send      = 1'b1;
          load      = 1'b1;
          load_byte = tx_data_i;
          sbit      = tx_data_i[0];
          nidx      = 3'd0;
`ifdef USB_TX_CRC16_EN
        end else if ((state == DATA) && crc_en) begin
          nstate    = CRC_LO;
          send      = 1'b1;
          load      = 1'b1;
          load_byte = ~crc[7:0];
          sbit      = ~crc[0];
          nidx      = 3'd0;
        end else if (state == CRC_LO) begin
          nstate    = CRC_HI;
          send      = 1'b1;
          load      = 1'b1;
          load_byte = ~crc[15:8];
          sbit      = ~crc[8];
          nidx      = 3'd0;
`endif
        end else begin
          nstate = EOP_SE0;
        end
      end
      default: begin
        nstate = state;
      end
    endcase
    nl = sbit ? line : ~line;
  end

  // The handshake pulse lands in the final clock of the slot that closes SYNC or a byte.
  always_comb begin
    rdy_next = ((state == SYNC) || (state == DATA)) && (cnt == SLOT_PRE) &&
               (bit_idx == 3'd7) && (ones != 3'd6) && tx_valid_i;
  end

  // Transmit FSM with registered pad, handshake and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      ones       <= 3'd0;
      line       <= 1'b1;
      eop_cnt    <= 1'b0;
      dp_tx_o    <= 1'b1;
      dn_tx_o    <= 1'b0;
      tx_oe_o    <= 1'b0;
      tx_busy_o  <= 1'b0;
      tx_ready_o <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc        <= 16'hFFFF;
      crc_en     <= 1'b0;
`endif
    end else begin
      tx_ready_o <= rdy_next;
      case (state)
        IDLE: begin
          cnt     <= '0;
          eop_cnt <= 1'b0;
          if (tx_valid_i) begin
            // SYNC bit 0 is a zero, so the line leaves J for K immediately.
            state     <= SYNC;
            tx_oe_o   <= 1'b1;
            tx_busy_o <= 1'b1;
            shreg     <= 8'h80;
            bit_idx   <= 3'd0;
            ones      <= 3'd0;
            line      <= 1'b0;
            dp_tx_o   <= 1'b0;
            dn_tx_o   <= 1'b1;
`ifdef USB_TX_CRC16_EN
            crc       <= 16'hFFFF;
            crc_en    <= tx_crc16_i;
`endif
          end
        end
        SYNC, DATA, CRC_LO, CRC_HI: begin
          if (slot_end) begin
            cnt   <= '0;
            state <= nstate;
            if (send) begin
              line    <= nl;
              dp_tx_o <= nl;
              dn_tx_o <= ~nl;
              ones    <= sbit ? (ones + 3'd1) : 3'd0;
              bit_idx <= nidx;
              if (load) begin
                shreg <= load_byte;
              end
`ifdef USB_TX_CRC16_EN
              if (load && (state == DATA) && (nstate == DATA)) begin
                crc <= crc16_byte(crc, tx_data_i);
              end
`endif
            end else begin
              dp_tx_o <= 1'b0;
              dn_tx_o <= 1'b0;
              eop_cnt <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EOP_SE0: begin
          if (slot_end) begin
            cnt <= '0;
            if (eop_cnt) begin
              state   <= EOP_J;
              line    <= 1'b1;
              dp_tx_o <= 1'b1;
              dn_tx_o <= 1'b0;
            end else begin
              eop_cnt <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EOP_J: begin
          if (slot_end) begin
            cnt       <= '0;
            state     <= IDLE;
            tx_oe_o   <= 1'b0;
            tx_busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          line      <= 1'b1;
          dp_tx_o   <= 1'b1;
          dn_tx_o   <= 1'b0;
          tx_oe_o   <= 1'b0;
          tx_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
